// File: rtl/regfile_scan_reader.sv
// Scans a run of register-file entries through a combinational read port and
// presents each captured value as a valid/ready beat tagged with its index.
module regfile_scan_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  start_idx,
  input  logic [5:0]  count,
  input  logic        abort,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cur_idx_q, cur_idx_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_idx_q, out_idx_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [5:0] clamp_count(input logic [5:0] c);
    return (c > 6'd32) ? 6'd32 : c;
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_idx_d   = start_idx;
          remaining_d = clamp_count(count);
          state_d     = (count == 6'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_data_d  = rd_data;
          out_idx_d   = cur_idx_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        // abort takes priority over a same-cycle handshake
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - 6'd1;
          if (remaining_q == 6'd1) begin
            state_d = DONE;
          end else begin
            cur_idx_d = cur_idx_q + 5'd1;
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // status flags are registered from the next state so they never glitch
    busy_d = (state_d != IDLE);
    done_d = (state_q != DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_idx_q   <= 5'd0;
      remaining_q <= 6'd0;
      out_data_q  <= 32'd0;
      out_idx_q   <= 5'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr   = cur_idx_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Bench for regfile_scan_reader: expected beats queued at scan start from a
// register-file array, popped and compared by an independent monitor.
module tb_regfile_scan_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  start_idx = 5'd0;
  logic [5:0]  count = 6'd0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [36:0] sb [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          scan_d0 = 0;
  int          mode = 0;
  logic        force_ready = 1'b1;

  assign rd_data = regs[rd_addr];

  regfile_scan_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_idx(start_idx), .count(count),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = controlled by the main sequence
  initial forever begin
    @(posedge clk);
    #2;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom % 2);
      default: out_ready = force_ready;
    endcase
  end

  // Monitor: beat compare, hold stability under backpressure, done pulse count
  logic        hold_pend = 1'b0;
  logic [36:0] hold_val = 37'd0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_beat", 64'({out_idx, out_data}), 64'(hold_val));
      end
      if (done) done_cnt++;
      if (out_valid && out_ready && !abort) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got idx %0d data %h, required no beat", out_idx, out_data);
        end else begin
          chk("beat", 64'({out_idx, out_data}), 64'(sb.pop_front()));
        end
      end
      hold_pend = out_valid && !out_ready && !abort;
      hold_val  = {out_idx, out_data};
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 with the first beat presented (count>0)
  task automatic start_scan(input logic [4:0] sidx, input logic [5:0] cnt);
    int n;
    logic [4:0] ix;
    n = (cnt > 6'd32) ? 32 : int'(cnt);
    for (int k = 0; k < n; k++) begin
      ix = 5'((int'(sidx) + k) % 32);
      sb.push_back({ix, regs[ix]});
    end
    scan_d0   = done_cnt;
    start     = 1'b1;
    start_idx = sidx;
    count     = cnt;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_idx = 5'($urandom);
    count     = 6'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    if (n > 0) begin
      chk("lat_edge1_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_edge2_valid", 64'(out_valid), 64'd1);
    end else begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_no_valid", 64'(out_valid), 64'd0);
    end
  endtask

  // Runs the scan out, firing ignored starts while busy
  task automatic finish_scan();
    int cyc;
    cyc = 0;
    while (busy && cyc < 500) begin
      start     = 1'($urandom % 2);
      start_idx = 5'($urandom);
      count     = 6'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("scan_end_busy", 64'(busy), 64'd0);
    chk("done_pulses", 64'(done_cnt - scan_d0), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int cyc;
    logic [31:0] sdata;
    logic [4:0]  sidx;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);

    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("idle");

    mode = 0;
    start_scan(5'd10, 6'd3);
    chk("first_beat_idx", 64'(out_idx), 64'd10);
    chk("first_beat_data", 64'(out_data), 64'h10A);
    finish_scan();
    start_scan(5'd30, 6'd4);
    finish_scan();
    start_scan(5'd0, 6'd0);
    finish_scan();
    start_scan(5'd0, 6'd40);
    finish_scan();

    // backpressure on the first beat, register rewritten after capture
    mode = 2;
    force_ready = 1'b0;
    start_scan(5'd10, 6'd3);
    sdata = out_data;
    sidx  = out_idx;
    regs[out_idx] = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'(sdata));
      chk("bp_idx", 64'(out_idx), 64'(sidx));
    end
    force_ready = 1'b1;
    finish_scan();

    // abort in HOLD of beat 2 of 5, with out_ready high in the same cycle
    start_scan(5'd5, 6'd5);
    cyc = 0;
    while (!(out_valid && out_idx == 5'd6) && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("abort_reached_beat2", 64'(out_idx), 64'd6);
    d = done_cnt;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d), 64'd0);
    chk("abort_beats_left", 64'(sb.size()), 64'd4);
    sb.delete();
    mode = 0;
    start_scan(5'd5, 6'd5);
    finish_scan();

    // asynchronous reset mid-scan
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    start_scan(5'd20, 6'd8);
    d = done_cnt;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_valid", 64'(out_valid), 64'd0);
    chk("postrst_no_done", 64'(done_cnt - d), 64'd0);

    // randomized scans with random backpressure
    mode = 1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      start_scan(5'($urandom), 6'($urandom_range(0, 40)));
      finish_scan();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
